// File: rtl/pattern_match_scheduler_pkg.sv
// rtl/pattern_match_scheduler_pkg.sv - shared types and constants for the pattern match scheduler
// Purpose: controller state enum, channel/pattern/counter sizes, reset pattern
//          and a one-hot to index helper shared by the scheduler files.
// Ports:   none (package).
package pattern_match_scheduler_pkg;

  localparam int NUM_CH = 4;
  localparam int PAT_W  = 4;
  localparam int CNT_W  = 8;
  localparam logic [PAT_W-1:0] DEFAULT_PATTERN = 4'b1101;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Index of the set bit in a one-hot channel vector (0 when none is set).
  function automatic logic [1:0] onehot_to_idx(input logic [NUM_CH-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (oh[k]) idx = 2'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pattern_match_scheduler_if.sv
// rtl/pattern_match_scheduler_if.sv - channel, configuration and status bundle of the scheduler
// Purpose: groups the run enable, per-channel request/data/grant, configuration
//          strobe, match report and counter read port.
// Ports:   master - drives en, req, bit_in, cfg_*, cnt_sel; observes gnt, match_*, cnt_out.
//          slave  - the scheduler side of the same signals.
interface pattern_match_scheduler_if;
  import pattern_match_scheduler_pkg::*;

  logic              en;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] bit_in;
  logic [NUM_CH-1:0] gnt;
  logic              cfg_we;
  logic [PAT_W-1:0]  cfg_pattern;
  logic              cfg_overlap;
  logic              match_valid;
  logic [1:0]        match_ch;
  logic [1:0]        cnt_sel;
  logic [CNT_W-1:0]  cnt_out;

  modport master (
    output en, req, bit_in, cfg_we, cfg_pattern, cfg_overlap, cnt_sel,
    input  gnt, match_valid, match_ch, cnt_out
  );

  modport slave (
    input  en, req, bit_in, cfg_we, cfg_pattern, cfg_overlap, cnt_sel,
    output gnt, match_valid, match_ch, cnt_out
  );

endinterface

// File: rtl/pattern_match_scheduler_rr_arbiter.sv
// rtl/pattern_match_scheduler_rr_arbiter.sv - combinational round-robin channel picker
// Purpose: grants the first requesting channel found searching ptr, ptr+1, ... mod 4.
// Ports:   req - per-channel request; ptr - search start; gnt - one-hot grant (0 if no req).
module rr_arbiter
  import pattern_match_scheduler_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [1:0]        ptr,
  output logic [NUM_CH-1:0] gnt
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    gnt   = '0;
    idx   = 2'd0;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pattern_match_scheduler.sv
// rtl/pattern_match_scheduler.sv - round-robin serial pattern matcher over four channels
// Purpose: takes one bit per cycle from a round-robin selected channel, runs it through
//          a shared matcher against that channel's history, reports matches and keeps
//          per-channel saturating match counters.
// Ports:   clk - clock; clr - asynchronous active-high reset;
//          io  - slave side of pattern_match_scheduler_if (en, req, bit_in, gnt,
//                cfg_we/cfg_pattern/cfg_overlap, match_valid/match_ch, cnt_sel/cnt_out).
module pattern_match_scheduler #(
  parameter int NUM_CH = 4,
  parameter int PAT_W  = 4
) (
  input logic                     clk,
  input logic                     clr,
  pattern_match_scheduler_if.slave io
);
  import pattern_match_scheduler_pkg::*;

  state_t            state;
  logic [PAT_W-1:0]  pattern;
  logic              overlap;
  logic [1:0]        ptr;
  logic [PAT_W-2:0]  hist [NUM_CH];
  logic [1:0]        fill [NUM_CH];
  logic [CNT_W-1:0]  cnt  [NUM_CH];
  logic              match_valid_q;
  logic [1:0]        match_ch_q;

  logic [NUM_CH-1:0] arb_gnt;
  logic [NUM_CH-1:0] gnt;
  logic              grant;
  logic [1:0]        gidx;
  logic [PAT_W-1:0]  window;
  logic              hit;

  rr_arbiter u_arb (
    .req (io.req),
    .ptr (ptr),
    .gnt (arb_gnt)
  );

  // A configuration write owns the cycle, so no channel is consumed alongside it.
  assign gnt    = (state == RUN && io.en && !io.cfg_we) ? arb_gnt : '0;
  assign grant  = |gnt;
  assign gidx   = onehot_to_idx(gnt);
  assign window = {hist[gidx], io.bit_in[gidx]};
  // fill==3 means three older bits are real, so the 4-bit window is fully populated.
  assign hit    = grant && (window == pattern) && (fill[gidx] == 2'd3);

  assign io.gnt         = gnt;
  assign io.match_valid = match_valid_q;
  assign io.match_ch    = match_ch_q;
  assign io.cnt_out     = cnt[io.cnt_sel];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state         <= IDLE;
      pattern       <= DEFAULT_PATTERN;
      overlap       <= 1'b1;
      ptr           <= 2'd0;
      match_valid_q <= 1'b0;
      match_ch_q    <= 2'd0;
      for (int i = 0; i < NUM_CH; i++) begin
        hist[i] <= '0;
        fill[i] <= 2'd0;
        cnt[i]  <= '0;
      end
    end else begin
      match_valid_q <= 1'b0;

      case (state)
        IDLE:    if (io.cfg_we) state <= RUN;
        RUN:     state <= RUN;
        default: state <= IDLE;
      endcase

      if (io.cfg_we) begin
        pattern <= io.cfg_pattern;
        overlap <= io.cfg_overlap;
        ptr     <= 2'd0;
        for (int i = 0; i < NUM_CH; i++) begin
          hist[i] <= '0;
          fill[i] <= 2'd0;
          cnt[i]  <= '0;
        end
      end else if (grant) begin
        ptr <= gidx + 2'd1;
        if (hit && !overlap) begin
          hist[gidx] <= '0;
          fill[gidx] <= 2'd0;
        end else begin
          hist[gidx] <= window[PAT_W-2:0];
          fill[gidx] <= (fill[gidx] == 2'd3) ? 2'd3 : fill[gidx] + 2'd1;
        end
        if (hit) begin
          match_valid_q <= 1'b1;
          match_ch_q    <= gidx;
          if (cnt[gidx] != '1) cnt[gidx] <= cnt[gidx] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pattern_match_scheduler.sv
// tb/tb_pattern_match_scheduler.sv - directed self-checking bench for pattern_match_scheduler
module tb_pattern_match_scheduler;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  pattern_match_scheduler_if io ();

  pattern_match_scheduler #(.NUM_CH(4), .PAT_W(4)) dut (
    .clk (clk),
    .clr (clr),
    .io  (io)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cfg(input logic [3:0] pat, input logic ov, input logic [3:0] req_during);
    @(negedge clk);
    io.cfg_we      = 1'b1;
    io.cfg_pattern = pat;
    io.cfg_overlap = ov;
    io.req         = req_during;
    io.bit_in      = 4'hF;
    #1 check("cfg_gnt", 32'(io.gnt), 32'h0);
    @(posedge clk);
    #1;
    io.cfg_we = 1'b0;
    io.req    = 4'h0;
  endtask

  // Presents one bit on a single channel, lets one edge pass, leaves time at edge+1.
  task automatic feed(input int ch, input logic b);
    @(negedge clk);
    io.req    = 4'(1 << ch);
    io.bit_in = {4{b}};
    @(posedge clk);
    #1;
    io.req = 4'h0;
  endtask

  task automatic feed_chk(input string tag, input int ch, input logic b, input logic exp_mv);
    feed(ch, b);
    check(tag, 32'(io.match_valid), 32'(exp_mv));
    if (exp_mv) check({tag, "_ch"}, 32'(io.match_ch), 32'(ch));
  endtask

  task automatic read_cnt(input string tag, input logic [1:0] sel, input int exp);
    io.cnt_sel = sel;
    #1 check(tag, 32'(io.cnt_out), 32'(exp));
  endtask

  initial begin
    logic [6:0] s7;
    logic [3:0] p4;
    logic [4:0] s5;
    logic [3:0] gexp;
    int         n_mv;

    clr            = 1'b1;
    io.en          = 1'b1;
    io.req         = 4'hF;
    io.bit_in      = 4'h0;
    io.cfg_we      = 1'b0;
    io.cfg_pattern = 4'h0;
    io.cfg_overlap = 1'b0;
    io.cnt_sel     = 2'd0;

    // Reset state
    #12;
    check("rst_gnt", 32'(io.gnt), 32'h0);
    check("rst_cnt", 32'(io.cnt_out), 32'h0);
    check("rst_mv", 32'(io.match_valid), 32'h0);
    check("rst_mch", 32'(io.match_ch), 32'h0);
    @(negedge clk);
    clr = 1'b0;
    #1 check("idle_gnt", 32'(io.gnt), 32'h0);
    @(posedge clk);
    #1 check("idle_gnt2", 32'(io.gnt), 32'h0);
    io.req = 4'h0;

    // ch0 alone: 1101 with overlap
    cfg(4'b1101, 1'b1, 4'b0001);
    feed_chk("s1_b0", 0, 1'b1, 1'b0);
    feed_chk("s1_b1", 0, 1'b1, 1'b0);
    feed_chk("s1_b2", 0, 1'b0, 1'b0);
    feed_chk("s1_b3", 0, 1'b1, 1'b1);
    read_cnt("s1_cnt0", 2'd0, 1);

    // ch1: 1101101, overlap then no overlap
    s7 = 7'b1101101;
    for (int i = 6; i >= 0; i--) feed_chk("s2_ov", 1, s7[i], (i == 3 || i == 0));
    read_cnt("s2_cnt1_ov", 2'd1, 2);
    cfg(4'b1101, 1'b0, 4'h0);
    read_cnt("s2_cnt1_clr", 2'd1, 0);
    read_cnt("s2_cnt0_clr", 2'd0, 0);
    for (int i = 6; i >= 0; i--) feed_chk("s2_nov", 1, s7[i], (i == 3));
    read_cnt("s2_cnt1_nov", 2'd1, 1);

    // All channels requesting: rotation, ch2 carries 1101
    cfg(4'b1101, 1'b1, 4'h0);
    p4 = 4'b1101;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      io.req    = 4'hF;
      io.bit_in = 4'h0;
      if (k % 4 == 2) io.bit_in[2] = p4[3 - k / 4];
      gexp = 4'(1 << (k % 4));
      #1 if (k < 5) check("s3_gnt", 32'(io.gnt), 32'(gexp));
      @(posedge clk);
      #1 check("s3_mv", 32'(io.match_valid), 32'(k == 14));
      if (k == 14) check("s3_mch", 32'(io.match_ch), 32'd2);
    end
    io.req = 4'h0;
    check("s3_mch_hold", 32'(io.match_ch), 32'd2);
    read_cnt("s3_cnt0", 2'd0, 0);
    read_cnt("s3_cnt1", 2'd1, 0);
    read_cnt("s3_cnt2", 2'd2, 1);
    read_cnt("s3_cnt3", 2'd3, 0);

    // ch3: partial 110, reconfigure to 0110 while requesting
    feed_chk("s4_pre", 3, 1'b1, 1'b0);
    feed_chk("s4_pre", 3, 1'b1, 1'b0);
    feed_chk("s4_pre", 3, 1'b0, 1'b0);
    cfg(4'b0110, 1'b1, 4'b1000);
    s5 = 5'b10110;
    for (int i = 4; i >= 0; i--) feed_chk("s4_seq", 3, s5[i], (i == 0));
    read_cnt("s4_cnt3", 2'd3, 1);

    // en=0 freezes grants and the pointer (ptr is 0 after ch3's grant)
    @(negedge clk);
    io.en  = 1'b0;
    io.req = 4'hF;
    #1 check("en0_gnt", 32'(io.gnt), 32'h0);
    @(negedge clk);
    io.en = 1'b1;
    #1 check("en0_ptr", 32'(io.gnt), 32'h1);
    io.req = 4'h0;

    // Counter saturation on ch0
    cfg(4'b1101, 1'b0, 4'h0);
    io.cnt_sel = 2'd0;
    n_mv = 0;
    for (int m = 0; m < 300; m++) begin
      feed(0, 1'b1);
      feed(0, 1'b1);
      feed(0, 1'b0);
      feed(0, 1'b1);
      if (io.match_valid) n_mv++;
      if (m == 253) check("s5_cnt254", 32'(io.cnt_out), 32'd254);
      if (m == 254) check("s5_cnt255", 32'(io.cnt_out), 32'd255);
    end
    check("s5_nmatch", 32'(n_mv), 32'd300);
    check("s5_sat", 32'(io.cnt_out), 32'd255);

    // clr between the 3rd and 4th bits
    cfg(4'b1101, 1'b1, 4'h0);
    feed_chk("s6_a", 0, 1'b1, 1'b0);
    feed_chk("s6_a", 0, 1'b1, 1'b0);
    feed_chk("s6_a", 0, 1'b0, 1'b0);
    feed_chk("s6_a", 0, 1'b1, 1'b1);
    feed_chk("s6_b", 0, 1'b1, 1'b0);
    feed_chk("s6_b", 0, 1'b1, 1'b0);
    feed_chk("s6_b", 0, 1'b0, 1'b0);
    @(negedge clk);
    io.req    = 4'h1;
    io.bit_in = 4'hF;
    #2 clr = 1'b1;
    #1 check("s6_clr_gnt", 32'(io.gnt), 32'h0);
    check("s6_clr_cnt", 32'(io.cnt_out), 32'h0);
    #1 clr = 1'b0;
    #1 check("s6_idle_gnt", 32'(io.gnt), 32'h0);
    @(posedge clk);
    #1 check("s6_no_mv", 32'(io.match_valid), 32'h0);
    io.req = 4'h0;
    cfg(4'b1101, 1'b1, 4'h0);
    feed_chk("s6_c", 0, 1'b1, 1'b0);
    feed_chk("s6_c", 0, 1'b1, 1'b0);
    feed_chk("s6_c", 0, 1'b0, 1'b0);
    feed_chk("s6_c", 0, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pattern_match_scheduler.md
PATTERN_MATCH_SCHEDULER -- requirements
Module: pattern_match_scheduler

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  NUM_CH, 4, number of serial input channels (fixed at 4 for this revision).
  PAT_W, 4, pattern length in bits.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all state changes on the rising edge.
  clr  in  1  reset, asynchronous, active-high.
  en  in  1  run enable; grants are issued only while high.
  req  in  4  per-channel valid: channel has a bit ready on bit_in.
  bit_in  in  4  per-channel serial data bit.
  gnt  out  4  one-hot grant/ready; bit_in[i] is consumed on the edge where gnt[i]=1.
  cfg_we  in  1  load-configuration strobe.
  cfg_pattern  in  4  pattern to detect, MSB is the first bit received.
  cfg_overlap  in  1  1 = overlapping matches allowed.
  match_valid  out  1  registered one-cycle match pulse.
  match_ch  out  2  channel that produced the match; valid with match_valid.
  cnt_sel  in  2  selects the channel counter to read.
  cnt_out  out  8  combinational read of the selected channel's match counter.

Function
REQ-003 SHALL implement a controller FSM with states IDLE and RUN; IDLE moves to RUN on cfg_we; RUN stays in RUN; only clr returns the FSM to IDLE.
REQ-004 SHALL drive gnt=0 in IDLE, while en=0, and in any cycle where cfg_we=1 (cfg_we has priority over grants).
REQ-005 In RUN with en=1 and cfg_we=0, SHALL combinationally grant exactly one requesting channel by round-robin, searching from ptr, ptr+1, ... (mod 4); gnt=0 if req=0.
REQ-006 SHALL set ptr to (granted index + 1) mod 4 on each grant edge; ptr SHALL be unchanged when there is no grant.
REQ-007 SHALL keep a per-channel context: hist[2:0] (last three bits consumed, newest in bit 0) and fill[1:0] (bits consumed, saturating at 3).
REQ-008 On a grant to channel i, the shared matcher SHALL evaluate {hist_i, bit_in[i]} == pattern && fill_i == 3.
REQ-009 On a grant with no match, SHALL update hist_i to {hist_i[1:0], bit_in[i]} and fill_i to min(fill_i+1, 3).
REQ-010 On a grant with a match and overlap=1, SHALL update the context as in REQ-009. With overlap=0, SHALL clear hist_i and fill_i to 0.
REQ-011 On a match, SHALL assert match_valid=1 and match_ch=i in the cycle after the grant edge; otherwise match_valid=0 and match_ch SHALL hold its last value.
REQ-012 SHALL increment channel i's 8-bit match counter on each match, saturating at 255 with no wrap.
REQ-013 On cfg_we, SHALL latch cfg_pattern and cfg_overlap. In the same edge it SHALL clear all hist, fill and counters, and set ptr=0. No bit is consumed in that cycle.
REQ-014 SHALL leave hist, fill, ptr and counters unchanged when en=0.
REQ-015 Contexts of non-granted channels SHALL never change on a grant edge.

Reset
REQ-016 When clr=1, SHALL asynchronously set: state=IDLE, pattern=4'b1101, overlap=1, ptr=0, all hist/fill=0, all counters=0, match_valid=0, match_ch=0.
REQ-017 While clr=1 (from REQ-016 and REQ-004), SHALL drive gnt=0, and cnt_out SHALL read 0.
REQ-018 Reset asserted mid-stream SHALL discard partial matches and any pending match_valid.

Structure
REQ-019 A shared package SHALL hold the state enum (IDLE, RUN), NUM_CH, PAT_W, CNT_W=8 and DEFAULT_PATTERN=4'b1101.
REQ-020 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, ptr; output one-hot gnt), purely combinational.
REQ-021 The matcher, contexts, counters and FSM SHALL live in pattern_match_scheduler; the target size is 120-400 RTL lines.

Verification
REQ-022 Bench SHALL cover these directed scenarios:
  - Reset, cfg_we with 1101 and overlap=1, en=1; ch0 alone feeds 1,1,0,1 -> match_valid=1, match_ch=0 one cycle after the 4th grant; cnt_sel=0 gives cnt_out=1.
  - ch1 alone feeds 1101101: overlap=1 -> 2 matches, cnt=2; reconfigure with overlap=0, same stream -> 1 match.
  - req=4'b1111 constantly -> gnt sequence 0001,0010,0100,1000,0001; ch2 feeds 1101 and the others feed 0 -> single match with match_ch=2 after ch2's 4th grant (edge 15); the other counters stay 0.
  - ch3 has fed 1,1,0; cfg_we with 0110 in the same cycle as req -> gnt=0 that cycle; following 1 -> no match; then 0,1,1,0 -> match.
  - 300 consecutive matches on ch0 (overlap=0) -> cnt_out saturates at 255.
  - clr pulsed between the 3rd and 4th bits of 1101 -> no match_valid; the pattern reverts to 1101 and the FSM to IDLE with gnt=0 until cfg_we.
